// File: rtl/l2_request_arbiter.sv
// Arbiter sequencing coherence transactions from two L1 controllers onto one L2/memory port.
// Write-backs win over misses; ties resolve round-robin; WAIT retires on abort, ack or timeout.
module l2_request_arbiter #(
  parameter int TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rstN,
  input  logic       reqC0,
  input  logic       reqC1,
  input  logic [1:0] opC0,
  input  logic [1:0] opC1,
  input  logic [7:0] addrC0,
  input  logic [7:0] addrC1,
  input  logic [7:0] wdataC0,
  input  logic [7:0] wdataC1,
  output logic       grantC0,
  output logic       grantC1,
  output logic       doneC0,
  output logic       doneC1,
  output logic [7:0] rdata,
  output logic       memReq,
  output logic       memWrite,
  output logic [7:0] memAddress,
  output logic [7:0] memWriteData,
  input  logic       memAck,
  input  logic [7:0] memReadData,
  input  logic       abortMem,
  input  logic [7:0] supplyData,
  output logic       timeoutErr,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam logic [1:0] OP_INV = 2'b10;
  localparam logic [1:0] OP_WB  = 2'b11;
  localparam logic [7:0] LAST_COUNT = 8'(TIMEOUT - 1);

  state_t     state;
  logic       lastGrant;
  logic       curId;
  logic [1:0] curOp;
  logic [7:0] count;

  logic       wbC0, wbC1, winner;
  logic [1:0] winOp;
  logic [7:0] winAddr, winWdata;
  logic       abortHit, timeoutHit, waitExit;

  always_comb begin
    wbC0 = reqC0 && (opC0 == OP_WB);
    wbC1 = reqC1 && (opC1 == OP_WB);
    // A lone write-back jumps the queue; otherwise the requester not served last wins a tie.
    if (wbC0 != wbC1)
      winner = wbC1;
    else if (reqC0 && reqC1)
      winner = ~lastGrant;
    else
      winner = reqC1;
    winOp    = winner ? opC1 : opC0;
    winAddr  = winner ? addrC1 : addrC0;
    winWdata = winner ? wdataC1 : wdataC0;
  end

  always_comb begin
    abortHit   = abortMem && (curOp != OP_WB);
    timeoutHit = (count == LAST_COUNT);
    waitExit   = abortHit || memAck || timeoutHit;
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state        <= IDLE;
      lastGrant    <= 1'b1;
      curId        <= 1'b0;
      curOp        <= 2'b00;
      count        <= 8'd0;
      rdata        <= 8'd0;
      grantC0      <= 1'b0;
      grantC1      <= 1'b0;
      doneC0       <= 1'b0;
      doneC1       <= 1'b0;
      timeoutErr   <= 1'b0;
      memReq       <= 1'b0;
      memWrite     <= 1'b0;
      memAddress   <= 8'd0;
      memWriteData <= 8'd0;
    end else begin
      grantC0    <= 1'b0;
      grantC1    <= 1'b0;
      doneC0     <= 1'b0;
      doneC1     <= 1'b0;
      timeoutErr <= 1'b0;
      case (state)
        IDLE: begin
          if (reqC0 || reqC1) begin
            curId     <= winner;
            curOp     <= winOp;
            lastGrant <= winner;
            grantC0   <= ~winner;
            grantC1   <= winner;
            count     <= 8'd0;
            if (winOp == OP_INV) begin
              // Invalidate needs no memory access: grant and done share one cycle.
              state  <= RESP;
              doneC0 <= ~winner;
              doneC1 <= winner;
            end else begin
              state        <= WAIT;
              memReq       <= 1'b1;
              memWrite     <= (winOp == OP_WB);
              memAddress   <= winAddr;
              memWriteData <= (winOp == OP_WB) ? winWdata : 8'd0;
            end
          end
        end
        WAIT: begin
          if (waitExit) begin
            state        <= RESP;
            doneC0       <= ~curId;
            doneC1       <= curId;
            memReq       <= 1'b0;
            memWrite     <= 1'b0;
            memAddress   <= 8'd0;
            memWriteData <= 8'd0;
            if (abortHit) begin
              rdata <= supplyData;
            end else if (memAck) begin
              if (curOp != OP_WB)
                rdata <= memReadData;
            end else begin
              rdata      <= 8'd0;
              timeoutErr <= 1'b1;
            end
          end else begin
            count <= count + 8'd1;
          end
        end
        RESP: begin
          state <= IDLE;
          count <= 8'd0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_l2_request_arbiter.sv
// Directed bench for l2_request_arbiter: a table of transactions plus a mid-transaction reset sequence.
module tb_l2_request_arbiter;

  logic       clk;
  logic       rstN;
  logic       reqC0, reqC1;
  logic [1:0] opC0, opC1;
  logic [7:0] addrC0, addrC1, wdataC0, wdataC1;
  logic       grantC0, grantC1, doneC0, doneC1;
  logic [7:0] rdata;
  logic       memReq, memWrite;
  logic [7:0] memAddress, memWriteData;
  logic       memAck;
  logic [7:0] memReadData;
  logic       abortMem;
  logic [7:0] supplyData;
  logic       timeoutErr, busy;

  int testsRun = 0;
  int failures = 0;

  l2_request_arbiter #(.TIMEOUT(16)) dut (
    .clk(clk), .rstN(rstN),
    .reqC0(reqC0), .reqC1(reqC1), .opC0(opC0), .opC1(opC1),
    .addrC0(addrC0), .addrC1(addrC1), .wdataC0(wdataC0), .wdataC1(wdataC1),
    .grantC0(grantC0), .grantC1(grantC1), .doneC0(doneC0), .doneC1(doneC1),
    .rdata(rdata), .memReq(memReq), .memWrite(memWrite),
    .memAddress(memAddress), .memWriteData(memWriteData),
    .memAck(memAck), .memReadData(memReadData),
    .abortMem(abortMem), .supplyData(supplyData),
    .timeoutErr(timeoutErr), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       r0, r1;
    logic [1:0] op0, op1;
    logic [7:0] a0, a1, w0, w1;
    int         ackCyc;      // WAIT cycle carrying memAck, 0 = never
    logic [7:0] ackData;
    int         abtCyc;      // WAIT cycle carrying abortMem, 0 = never
    logic [7:0] supData;
    logic       expId;
    int         expDone;     // cycle of done, counted from the accepting edge
    logic [7:0] expRdata;
    logic       expTo;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic runVec(input vec_t v, input int idx);
    logic [1:0] expMask;
    logic [1:0] expOp;
    logic [7:0] expAddr, expWd;
    int         memReqCycles, strays, doneCyc;
    logic       doneSeen;
    expMask = v.expId ? 2'b10 : 2'b01;
    expOp   = v.expId ? v.op1 : v.op0;
    expAddr = v.expId ? v.a1 : v.a0;
    expWd   = (expOp == 2'b11) ? (v.expId ? v.w1 : v.w0) : 8'h00;
    reqC0 = v.r0; reqC1 = v.r1; opC0 = v.op0; opC1 = v.op1;
    addrC0 = v.a0; addrC1 = v.a1; wdataC0 = v.w0; wdataC1 = v.w1;
    memReqCycles = 0; strays = 0; doneCyc = 0; doneSeen = 1'b0;
    for (int c = 1; c <= 40 && !doneSeen; c++) begin
      @(posedge clk); #1;
      if (c == 1)
        check($sformatf("v%0d grant", idx), {30'd0, grantC1, grantC0}, {30'd0, expMask});
      else if (grantC0 || grantC1)
        strays++;
      if (memReq) begin
        memReqCycles++;
        if (memReqCycles == 1) begin
          check($sformatf("v%0d memAddress", idx), {24'd0, memAddress}, {24'd0, expAddr});
          check($sformatf("v%0d memWrite", idx), {31'd0, memWrite}, {31'd0, expOp == 2'b11});
          check($sformatf("v%0d memWriteData", idx), {24'd0, memWriteData}, {24'd0, expWd});
        end
      end
      if (doneC0 || doneC1) begin
        doneSeen = 1'b1;
        doneCyc  = c;
        check($sformatf("v%0d done_id", idx), {30'd0, doneC1, doneC0}, {30'd0, expMask});
        check($sformatf("v%0d rdata", idx), {24'd0, rdata}, {24'd0, v.expRdata});
        check($sformatf("v%0d timeoutErr", idx), {31'd0, timeoutErr}, {31'd0, v.expTo});
      end else if (timeoutErr) begin
        strays++;
      end
      memAck      = (c == v.ackCyc);
      memReadData = v.ackData;
      abortMem    = (c == v.abtCyc);
      supplyData  = v.supData;
    end
    memAck = 1'b0; abortMem = 1'b0; reqC0 = 1'b0; reqC1 = 1'b0;
    if (!doneSeen)
      check($sformatf("v%0d done_within_budget", idx), 32'd0, 32'd1);
    else
      check($sformatf("v%0d done_cycle", idx), doneCyc, v.expDone);
    check($sformatf("v%0d memReq_cycles", idx), memReqCycles, v.expDone - 1);
    check($sformatf("v%0d stray_pulses", idx), strays, 0);
    @(posedge clk); #1;
    check($sformatf("v%0d idle_state", idx),
          {22'd0, busy, memReq, memAddress},
          32'd0);
    $display("[TB] v%0d: winner C%0d, done cycle %0d, rdata %02h, timeoutErr %0d",
             idx, v.expId, doneCyc, rdata, v.expTo);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int strayDone;
    //            r0   r1   op0   op1   a0     a1     w0     w1    ack ackD  abt sup    id  done rdata  to
    vecs[0]  = '{1'b1,1'b0,2'd0,2'd0,8'h2D,8'h00,8'h00,8'h00, 1,8'hA5, 0,8'h00,1'b0, 2,8'hA5,1'b0};
    vecs[1]  = '{1'b1,1'b1,2'd0,2'd0,8'h11,8'h21,8'h00,8'h00, 1,8'h11, 0,8'h00,1'b1, 2,8'h11,1'b0};
    vecs[2]  = '{1'b1,1'b1,2'd0,2'd0,8'h12,8'h22,8'h00,8'h00, 1,8'h22, 0,8'h00,1'b0, 2,8'h22,1'b0};
    vecs[3]  = '{1'b1,1'b1,2'd0,2'd0,8'h13,8'h23,8'h00,8'h00, 1,8'h33, 0,8'h00,1'b1, 2,8'h33,1'b0};
    vecs[4]  = '{1'b1,1'b1,2'd0,2'd0,8'h14,8'h24,8'h00,8'h00, 1,8'h44, 0,8'h00,1'b0, 2,8'h44,1'b0};
    vecs[5]  = '{1'b1,1'b1,2'd0,2'd3,8'h40,8'h11,8'h00,8'h3C, 2,8'hEE, 0,8'h00,1'b1, 3,8'h44,1'b0};
    vecs[6]  = '{1'b1,1'b0,2'd0,2'd0,8'h40,8'h00,8'h00,8'h00, 1,8'h5A, 0,8'h00,1'b0, 2,8'h5A,1'b0};
    vecs[7]  = '{1'b0,1'b1,2'd0,2'd0,8'h00,8'h33,8'h00,8'h00, 1,8'h99, 1,8'h77,1'b1, 2,8'h77,1'b0};
    vecs[8]  = '{1'b0,1'b1,2'd0,2'd3,8'h00,8'h34,8'h00,8'h12, 3,8'h55, 1,8'h77,1'b1, 4,8'h77,1'b0};
    vecs[9]  = '{1'b1,1'b0,2'd0,2'd0,8'h2A,8'h00,8'h00,8'h00, 0,8'h00, 0,8'h00,1'b0,17,8'h00,1'b1};
    vecs[10] = '{1'b1,1'b0,2'd2,2'd0,8'h08,8'h00,8'h00,8'h00, 0,8'h00, 0,8'h00,1'b0, 1,8'h00,1'b0};
    vecs[11] = '{1'b1,1'b1,2'd3,2'd3,8'h50,8'h51,8'hA1,8'hB2, 1,8'hFF, 0,8'h00,1'b1, 2,8'h00,1'b0};
    vecs[12] = '{1'b1,1'b0,2'd1,2'd0,8'h2C,8'h00,8'h00,8'h00, 2,8'hC3, 0,8'h00,1'b0, 3,8'hC3,1'b0};
    vecs[13] = '{1'b1,1'b1,2'd0,2'd0,8'h2D,8'h3E,8'h00,8'h00, 1,8'h6B, 0,8'h00,1'b0, 2,8'h6B,1'b0};

    rstN = 1'b0;
    reqC0 = 1'b0; reqC1 = 1'b0; opC0 = 2'd0; opC1 = 2'd0;
    addrC0 = 8'h00; addrC1 = 8'h00; wdataC0 = 8'h00; wdataC1 = 8'h00;
    memAck = 1'b0; memReadData = 8'h00; abortMem = 1'b0; supplyData = 8'h00;

    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs",
          {busy, memReq, memWrite, grantC0, grantC1, doneC0, doneC1, timeoutErr, rdata, memAddress, memWriteData},
          32'd0);
    $display("[TB] reset: busy %0d memReq %0d rdata %02h", busy, memReq, rdata);
    rstN = 1'b1;

    for (int i = 0; i < 13; i++)
      runVec(vecs[i], i);

    // C0 read left hanging in WAIT, then reset asserted between clock edges.
    reqC0 = 1'b1; opC0 = 2'd0; addrC0 = 8'h2D; reqC1 = 1'b0;
    @(posedge clk); #1;
    check("rst_seq grantC0", {31'd0, grantC0}, 32'd1);
    @(posedge clk); #1;
    @(posedge clk); #3;
    check("rst_seq memReq_before", {31'd0, memReq}, 32'd1);
    rstN = 1'b0;
    #1;
    check("rst_seq async_drop", {busy, memReq, rdata, memAddress}, 32'd0);
    $display("[TB] async reset: memReq %0d busy %0d rdata %02h", memReq, busy, rdata);
    reqC1 = 1'b1; opC1 = 2'd0; addrC1 = 8'h3E;
    strayDone = 0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      if (doneC0 || doneC1 || grantC0 || grantC1) strayDone++;
    end
    check("rst_seq no_done", strayDone, 0);
    rstN = 1'b1;
    runVec(vecs[13], 13);

    $display("[TB] %0d tests run, %0d failed", testsRun, failures);
    $finish;
  end

endmodule
